ccg_sig_collector: RTL

- Sequential test-harness block that sits on the opposite side of a CCGRCG-style combinational benchmark circuit: it generates the circuit's input vectors x0..x(NIN-1) and reads back its outputs f1..fNOUT.
- On start, it sweeps all 2^NIN input vectors exhaustively.
- Each response is compacted into a Galois MISR signature, compared against an expected golden value, and returned over a valid/ready handshake.
- Used for gate-level equivalence checks of the resynthesised netlists in the dataset.

---
 rtl/ccg_sig_collector_pkg.sv | 18 +
 rtl/ccg_sig_collector_misr.sv | 40 ++++
 rtl/ccg_sig_collector.sv | 131 +++++++++++++
 3 files changed

// File: rtl/ccg_sig_collector_pkg.sv
// Shared types and defaults for the CCG signature-collector harness.
// Holds the sweep FSM states, the default MISR constants and the signature type.
package ccg_tb_pkg;

    localparam int          SIGW_DEF = 16;
    localparam logic [15:0] POLY_DEF = 16'h1021;
    localparam logic [15:0] SEED_DEF = 16'h0000;

    typedef logic [SIGW_DEF-1:0] sig_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } ccg_state_e;

endpackage

// File: rtl/ccg_sig_collector_misr.sv
// Galois MISR: shift left, XOR POLY when the outgoing MSB is set, XOR in data.
// load has priority over en so a new sweep always starts from the seed.
module ccg_misr
    import ccg_tb_pkg::*;
#(
    parameter int              SIGW = 16,
    parameter logic [SIGW-1:0] POLY = SIGW'(POLY_DEF)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [SIGW-1:0] seed,
    input  logic            en,
    input  logic [SIGW-1:0] data_i,
    output logic [SIGW-1:0] sig_o
);

    logic [SIGW-1:0] sig_q;
    logic [SIGW-1:0] sig_d;

    always_comb begin
        sig_d = sig_q;
        if (load) begin
            sig_d = seed;
        end else if (en) begin
            sig_d = {sig_q[SIGW-2:0], 1'b0} ^ (sig_q[SIGW-1] ? POLY : '0) ^ data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig_o = sig_q;

endmodule

// File: rtl/ccg_sig_collector.sv
// Exhaustive-sweep harness: drives 2^NIN vectors into a benchmark circuit, folds
// the DUT_LAT-delayed responses into a MISR and offers the signature on valid/ready.
module ccg_sig_collector
    import ccg_tb_pkg::*;
#(
    parameter int              NIN     = 6,
    parameter int              NOUT    = 14,
    parameter int              SIGW    = 16,
    parameter logic [SIGW-1:0] POLY    = SIGW'(POLY_DEF),
    parameter logic [SIGW-1:0] SEED    = SIGW'(SEED_DEF),
    parameter int              DUT_LAT = 0,
    parameter logic [SIGW-1:0] EXPECT  = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    output logic            busy,
    output logic [NIN-1:0]  vec_o,
    input  logic [NOUT-1:0] resp_i,
    output logic            sig_valid,
    input  logic            sig_ready,
    output logic [SIGW-1:0] sig_o,
    output logic            pass_o,
    output ccg_state_e      state_dbg
);

    // Handshake: the signature transfers on a cycle where sig_valid && sig_ready;
    // while sig_valid && !sig_ready, sig_o and pass_o do not change.

    localparam int           CW   = NIN + 1;
    localparam logic [CW-1:0] LAST = CW'((1 << NIN) - 1);
    // Tag pipeline is at least one bit wide so DUT_LAT=0 needs no special-case ports.
    localparam int           PW   = (DUT_LAT > 0) ? DUT_LAT : 1;
    localparam logic [PW-1:0] TAG_MSB = PW'(1) << (PW - 1);

    ccg_state_e      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   tag_q, tag_d;
    logic            run_tag;
    logic            cap_en;
    logic            drain_done;
    logic            misr_load;
    logic [SIGW-1:0] misr_data;
    logic [SIGW-1:0] misr_sig;

    assign run_tag    = (state_q == RUN);
    assign cap_en     = (DUT_LAT == 0) ? run_tag : tag_q[PW-1];
    // After this cycle only the emerging stage may still hold a tag.
    assign drain_done = ((tag_q & ~TAG_MSB) == '0);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tag_d     = (tag_q << 1) | PW'(run_tag);
        misr_load = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    misr_load = 1'b1;
                    cnt_d     = '0;
                    state_d   = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    tag_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        state_d = (DUT_LAT > 0) ? DRAIN : DONE;
                    end
                end
            end
            DRAIN: begin
                if (abort) begin
                    state_d = IDLE;
                    tag_d   = '0;
                end else if (drain_done) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (sig_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            tag_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tag_q   <= tag_d;
        end
    end

    always_comb begin
        misr_data             = '0;
        misr_data[NOUT-1:0]   = resp_i;
    end

    ccg_misr #(
        .SIGW (SIGW),
        .POLY (POLY)
    ) u_misr (
        .clk    (clk),
        .rst    (rst),
        .load   (misr_load),
        .seed   (SEED),
        .en     (cap_en),
        .data_i (misr_data),
        .sig_o  (misr_sig)
    );

    assign busy      = (state_q == RUN) || (state_q == DRAIN);
    assign vec_o     = (state_q == RUN) ? cnt_q[NIN-1:0] : '0;
    assign sig_valid = (state_q == DONE);
    assign sig_o     = sig_valid ? misr_sig : '0;
    assign pass_o    = sig_valid && (misr_sig == EXPECT);
    assign state_dbg = state_q;

endmodule
